// File: rtl/twos_complement_serial.sv
// Digit-serial two's-complement pass/negate/abs/-abs unit with valid/ready handshakes.
// Optional macro TWOS_COMP_SATURATE_EN: clamp overflowing results to the most positive value.
module twos_complement_serial #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] IN_DATA,
    input  logic [1:0]       MODE,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] OUT_DATA,
    output logic             OVF
);

    localparam int NCHUNK = WIDTH / DIGIT;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0]    LAST     = CW'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t state_q, state_d;

    logic signed [WIDTH-1:0] opnd_q;
    logic signed [WIDTH-1:0] res_q;
    logic                    neg_q;
    logic                    seen_q;
    logic                    ovf_q;
    logic                    armed_q;
    logic [CW-1:0]           cnt_q;

    logic                    accept;
    logic                    last_chunk;
    logic                    in_sign;
    logic                    in_neg;
    logic [DIGIT-1:0]        chunk;
    logic                    seen_d;
    logic signed [WIDTH-1:0] res_shift;
    logic signed [WIDTH-1:0] res_d;

`ifdef TWOS_COMP_SATURATE_EN
    function automatic logic signed [WIDTH-1:0] saturate(input logic signed [WIDTH-1:0] r,
                                                         input logic ovf);
        return ovf ? $signed({1'b0, {(WIDTH-1){1'b1}}}) : r;
    endfunction
`endif

    // armed_q keeps IN_READY low until the first clock edge after reset release
    always_comb begin
        IN_READY  = armed_q & ((state_q == IDLE) | ((state_q == DONE) & OUT_READY));
        accept    = IN_VALID & IN_READY;
        OUT_VALID = (state_q == DONE);
        OVF       = (state_q == DONE) & ovf_q;
        OUT_DATA  = res_q;
    end

    always_comb begin
        in_sign    = IN_DATA[WIDTH-1];
        in_neg     = (MODE == 2'b01) | ((MODE == 2'b10) & in_sign) |
                     ((MODE == 2'b11) & ~in_sign & (IN_DATA != '0));
        last_chunk = (cnt_q == LAST);
    end

    // Bits pass unchanged up to and including the first 1, then invert when negating
    always_comb begin
        chunk  = '0;
        seen_d = seen_q;
        for (int i = 0; i < DIGIT; i++) begin
            chunk[i] = opnd_q[i] ^ (neg_q & seen_d);
            seen_d   = seen_d | opnd_q[i];
        end
        res_shift = (res_q >> DIGIT) | (WIDTH'(chunk) << (WIDTH - DIGIT));
`ifdef TWOS_COMP_SATURATE_EN
        res_d = last_chunk ? saturate(res_shift, ovf_q) : res_shift;
`else
        res_d = res_shift;
`endif
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = BUSY;
            BUSY:    if (last_chunk) state_d = DONE;
            DONE:    if (OUT_READY) state_d = accept ? BUSY : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            armed_q <= 1'b1;
        end
    end

    // Operand shifts out LSB-first while the result fills from the top
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            opnd_q <= '0;
            res_q  <= '0;
            neg_q  <= 1'b0;
            seen_q <= 1'b0;
            ovf_q  <= 1'b0;
            cnt_q  <= '0;
        end else if (accept) begin
            opnd_q <= IN_DATA;
            neg_q  <= in_neg;
            ovf_q  <= in_neg & (IN_DATA == MOST_NEG);
            seen_q <= 1'b0;
            cnt_q  <= '0;
        end else if (state_q == BUSY) begin
            opnd_q <= opnd_q >> DIGIT;
            seen_q <= seen_d;
            res_q  <= res_d;
            cnt_q  <= cnt_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_twos_complement_serial.sv
// Directed bench for twos_complement_serial: default 8/2, plus 16/4 and 8/1 instances.
module tb_twos_complement_serial;

    logic        CLK;
    logic        RESET_N;
    logic [15:0] din;
    logic [1:0]  mode;
    logic [2:0]  iv, ordy, ir, ov, of;
    logic [7:0]  dout_a, dout_c;
    logic [15:0] dout_b;

    int total = 0;
    int bad   = 0;
    int n;

`ifdef TWOS_COMP_SATURATE_EN
    localparam logic [15:0] OVR8  = 16'h007F;
    localparam logic [15:0] OVR16 = 16'h7FFF;
`else
    localparam logic [15:0] OVR8  = 16'h0080;
    localparam logic [15:0] OVR16 = 16'h8000;
`endif

    twos_complement_serial #(.WIDTH(8), .DIGIT(2)) dut_a (
        .CLK(CLK), .RESET_N(RESET_N), .IN_VALID(iv[0]), .IN_READY(ir[0]),
        .IN_DATA(din[7:0]), .MODE(mode), .OUT_VALID(ov[0]), .OUT_READY(ordy[0]),
        .OUT_DATA(dout_a), .OVF(of[0]));

    twos_complement_serial #(.WIDTH(16), .DIGIT(4)) dut_b (
        .CLK(CLK), .RESET_N(RESET_N), .IN_VALID(iv[1]), .IN_READY(ir[1]),
        .IN_DATA(din), .MODE(mode), .OUT_VALID(ov[1]), .OUT_READY(ordy[1]),
        .OUT_DATA(dout_b), .OVF(of[1]));

    twos_complement_serial #(.WIDTH(8), .DIGIT(1)) dut_c (
        .CLK(CLK), .RESET_N(RESET_N), .IN_VALID(iv[2]), .IN_READY(ir[2]),
        .IN_DATA(din[7:0]), .MODE(mode), .OUT_VALID(ov[2]), .OUT_READY(ordy[2]),
        .OUT_DATA(dout_c), .OVF(of[2]));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] dsel(input int k);
        if (k == 0) return {8'h00, dout_a};
        if (k == 1) return dout_b;
        return {8'h00, dout_c};
    endfunction

    // One transaction on instance k: accept, scramble inputs while busy, measure latency, consume
    task automatic run(input int k, input logic [1:0] m, input logic [15:0] d,
                       input logic [15:0] e, input logic eo, input int lat, input string tag);
        int cyc;
        @(posedge CLK); #1;
        check({tag, "_rdy"}, 16'(ir[k]), 16'd1);
        iv[k] = 1'b1; mode = m; din = d;
        @(posedge CLK); #1;
        iv[k] = 1'b0; din = 16'hA5C3; mode = ~m;
        cyc = 0;
        while (!ov[k] && cyc < 40) begin
            @(negedge CLK);
            cyc++;
        end
        check({tag, "_lat"}, 16'(cyc - 1), 16'(lat));
        check({tag, "_data"}, dsel(k), e);
        check({tag, "_ovf"}, 16'(of[k]), 16'(eo));
        ordy[k] = 1'b1;
        @(posedge CLK); #1;
        ordy[k] = 1'b0;
    endtask

    initial begin
        RESET_N = 1'b1; din = '0; mode = '0; iv = '0; ordy = '0;
        #2 RESET_N = 1'b0;
        @(negedge CLK);
        check("reset_ir", 16'(ir[0]), 16'd0);
        check("reset_ov", 16'(ov[0]), 16'd0);
        check("reset_dout", dsel(0), 16'h0000);
        check("reset_ovf", 16'(of[0]), 16'd0);
        @(posedge CLK); #1;
        RESET_N = 1'b1;

        run(0, 2'b01, 16'h0002, 16'h00FE, 1'b0, 4, "neg2");
        run(0, 2'b10, 16'h00FB, 16'h0005, 1'b0, 4, "abs_m5");
        run(0, 2'b11, 16'h0008, 16'h00F8, 1'b0, 4, "nabs8");
        run(0, 2'b00, 16'h0003, 16'h0003, 1'b0, 4, "pass3");
        run(0, 2'b01, 16'h0080, OVR8,     1'b1, 4, "neg_min");
        run(0, 2'b10, 16'h0080, OVR8,     1'b1, 4, "abs_min");
        run(0, 2'b11, 16'h0080, 16'h0080, 1'b0, 4, "nabs_min");
        run(0, 2'b11, 16'h0000, 16'h0000, 1'b0, 4, "nabs_zero");

        // IN_VALID held throughout: no second accept while busy or stalled in DONE
        @(posedge CLK); #1;
        iv[0] = 1'b1; mode = 2'b01; din = 16'h0007;
        @(posedge CLK); #1;
        din = 16'h0033; mode = 2'b00;
        check("hold_busy_ir", 16'(ir[0]), 16'd0);
        n = 0;
        while (!ov[0] && n < 40) begin
            @(negedge CLK);
            n++;
        end
        check("hold_lat", 16'(n - 1), 16'd4);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("hold_dout", dsel(0), 16'h00F9);
            check("hold_ov", 16'(ov[0]), 16'd1);
            check("hold_ir", 16'(ir[0]), 16'd0);
        end
        ordy[0] = 1'b1; din = 16'h0005; mode = 2'b01;
        @(posedge CLK); #1;
        ordy[0] = 1'b0; iv[0] = 1'b0; din = 16'h0044;
        check("b2b_ov", 16'(ov[0]), 16'd0);
        check("b2b_ir", 16'(ir[0]), 16'd0);
        n = 0;
        while (!ov[0] && n < 40) begin
            @(negedge CLK);
            n++;
        end
        check("b2b_lat", 16'(n - 1), 16'd4);
        check("b2b_dout", dsel(0), 16'h00FB);
        check("b2b_ovf", 16'(of[0]), 16'd0);
        ordy[0] = 1'b1;
        @(posedge CLK); #1;
        ordy[0] = 1'b0;

        // Reset in the second BUSY cycle aborts the operation at once
        @(posedge CLK); #1;
        iv[0] = 1'b1; mode = 2'b01; din = 16'h0009;
        @(posedge CLK); #1;
        iv[0] = 1'b0;
        @(posedge CLK); #1;
        RESET_N = 1'b0;
        #1;
        check("abort_ov", 16'(ov[0]), 16'd0);
        check("abort_ir", 16'(ir[0]), 16'd0);
        check("abort_dout", dsel(0), 16'h0000);
        check("abort_ovf", 16'(of[0]), 16'd0);
        @(posedge CLK); #1;
        RESET_N = 1'b1;
        run(0, 2'b01, 16'h0000, 16'h0000, 1'b0, 4, "neg_zero");

        run(1, 2'b01, 16'h0002, 16'hFFFE, 1'b0, 4, "w16_neg2");
        run(1, 2'b01, 16'h8000, OVR16,    1'b1, 4, "w16_min");
        run(2, 2'b01, 16'h0002, 16'h00FE, 1'b0, 8, "d1_neg2");
        run(2, 2'b01, 16'h0080, OVR8,     1'b1, 8, "d1_min");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
